// File: rtl/countdown_timer.sv
// Countdown timer, mm:ss in BCD, counted down by an external 1 Hz tick.
// After reaching 00:00 it holds an alarm for ALARM_TICKS ticks, then
// returns to idle on its own.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | stopped; count holds the last preset or 00:00
// S_RUN   | counting down one second per tick_1hz
// S_PAUSE | counting suspended; start resumes it
// S_DONE  | reached 00:00; alarm asserted until ALARM_TICKS ticks pass
//
// Command priority each cycle: load > stop > pause > start.
// A pause that cannot act (outside S_RUN) does not block a start.
module countdown_timer #(
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic       load_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  alarm_cnt;
    logic [15:0] count_bcd;
    logic        preset_ok;
    logic        count_is_zero;
    logic        count_is_one;

    // One-second decrement with borrow through every digit; the caller
    // guarantees the count is non-zero.
    function automatic logic [15:0] dec_bcd(input logic [15:0] c);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        {mt, mo, st, so} = c;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Preset validity and count terminal compares.
    always_comb begin
        count_bcd     = {min_tens, min_ones, sec_tens, sec_ones};
        preset_ok     = (set_min[7:4] <= 4'd5) && (set_min[3:0] <= 4'd9) &&
                        (set_sec[7:4] <= 4'd5) && (set_sec[3:0] <= 4'd9);
        count_is_zero = (count_bcd == 16'h0000);
        count_is_one  = (count_bcd == 16'h0001);
    end

    // Controller FSM with count, alarm down-counter and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            min_tens  <= 4'd0;
            min_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
            running   <= 1'b0;
            done      <= 1'b0;
            alarm     <= 1'b0;
            load_err  <= 1'b0;
            alarm_cnt <= 8'd0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (preset_ok) begin
                    {min_tens, min_ones} <= set_min;
                    {sec_tens, sec_ones} <= set_sec;
                    state     <= S_IDLE;
                    running   <= 1'b0;
                    alarm     <= 1'b0;
                    alarm_cnt <= 8'd0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (stop) begin
                state     <= S_IDLE;
                running   <= 1'b0;
                alarm     <= 1'b0;
                alarm_cnt <= 8'd0;
            end else if (pause && state == S_RUN) begin
                state   <= S_PAUSE;
                running <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_PAUSE: begin
                        if (start && !count_is_zero) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (tick_1hz) begin
                            if (count_is_one) begin
                                {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
                                state     <= S_DONE;
                                running   <= 1'b0;
                                alarm     <= 1'b1;
                                done      <= 1'b1;
                                alarm_cnt <= 8'(ALARM_TICKS);
                            end else if (!count_is_zero) begin
                                {min_tens, min_ones, sec_tens, sec_ones} <= dec_bcd(count_bcd);
                            end
                        end
                    end
                    S_DONE: begin
                        if (tick_1hz) begin
                            if (alarm_cnt <= 8'd1) begin
                                state     <= S_IDLE;
                                alarm     <= 1'b0;
                                alarm_cnt <= 8'd0;
                            end else begin
                                alarm_cnt <= alarm_cnt - 8'd1;
                            end
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        running <= 1'b0;
                        alarm   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios followed by random
// commands, compared cycle by cycle against a seconds-based model.
module tb_countdown_timer;

    localparam int AT = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       load = 1'b0;
    logic [7:0] set_min = 8'h00;
    logic [7:0] set_sec = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done, alarm, load_err;

    int errors = 0;
    int checks = 0;
    int cycle_n = 0;

    logic [19:0] exp_q[$];
    logic [19:0] dut_vec;

    int m_state;
    int m_secs;
    int m_alarm_left;
    bit m_done;
    bit m_lerr;

    countdown_timer #(.ALARM_TICKS(AT)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .load     (load),
        .set_min  (set_min),
        .set_sec  (set_sec),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .done     (done),
        .alarm    (alarm),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    assign dut_vec = {min_tens, min_ones, sec_tens, sec_ones, running, done, alarm, load_err};

    function automatic bit bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [19:0] model_vec();
        int mins;
        int s;
        mins = m_secs / 60;
        s    = m_secs % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10),
                (m_state == M_RUN), m_done, (m_state == M_DONE), m_lerr};
    endfunction

    task automatic model_reset();
        m_state      = M_IDLE;
        m_secs       = 0;
        m_alarm_left = 0;
        m_done       = 1'b0;
        m_lerr       = 1'b0;
    endtask

    task automatic model_step(input bit ld, input logic [7:0] mn, input logic [7:0] sc,
                              input bit st, input bit ps, input bit sp, input bit tk);
        m_done = 1'b0;
        m_lerr = 1'b0;
        if (ld) begin
            if (bcd_ok(mn) && bcd_ok(sc)) begin
                m_secs  = (int'(mn[7:4]) * 10 + int'(mn[3:0])) * 60 +
                          int'(sc[7:4]) * 10 + int'(sc[3:0]);
                m_state = M_IDLE;
            end else begin
                m_lerr = 1'b1;
            end
        end else if (sp) begin
            m_state = M_IDLE;
        end else if (ps && m_state == M_RUN) begin
            m_state = M_PAUSE;
        end else if ((m_state == M_IDLE || m_state == M_PAUSE) && st && m_secs != 0) begin
            m_state = M_RUN;
        end else if (m_state == M_RUN && tk && m_secs > 0) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_state      = M_DONE;
                m_done       = 1'b1;
                m_alarm_left = AT;
            end
        end else if (m_state == M_DONE && tk) begin
            m_alarm_left = m_alarm_left - 1;
            if (m_alarm_left == 0) m_state = M_IDLE;
        end
    endtask

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mmss + flags run/done/alarm/lerr)",
                     name, act, exp);
        end
    endtask

    task automatic cyc(input bit ld, input logic [7:0] mn, input logic [7:0] sc,
                       input bit st, input bit ps, input bit sp, input bit tk);
        @(negedge clk);
        #1;
        rst      = 1'b0;
        load     = ld;
        set_min  = mn;
        set_sec  = sc;
        start    = st;
        pause    = ps;
        stop     = sp;
        tick_1hz = tk;
        model_step(ld, mn, sc, st, ps, sp, tk);
        exp_q.push_back(model_vec());
    endtask

    task automatic nop();                                   cyc(0, 8'h00, 8'h00, 0, 0, 0, 0); endtask
    task automatic tick();                                  cyc(0, 8'h00, 8'h00, 0, 0, 0, 1); endtask
    task automatic go();                                    cyc(0, 8'h00, 8'h00, 1, 0, 0, 0); endtask
    task automatic ld(input logic [7:0] m, input logic [7:0] s); cyc(1, m, s, 0, 0, 0, 0); endtask

    // Reset raised between clock edges; outputs must clear before the next edge.
    task automatic async_rst(input string name);
        @(negedge clk);
        #1;
        load = 0; start = 0; pause = 0; stop = 0; tick_1hz = 0;
        #2;
        rst = 1'b1;
        #1;
        chk(name, dut_vec, 20'h00000);
        model_reset();
        exp_q.push_back(model_vec());
    endtask

    function automatic logic [7:0] rand_preset(input bit minutes);
        logic [3:0] t;
        logic [3:0] o;
        if ($urandom_range(0, 11) == 0) t = 4'($urandom_range(6, 15));
        else if (minutes) t = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 5)) : 4'd0;
        else t = 4'($urandom_range(0, 1));
        if ($urandom_range(0, 11) == 0) o = 4'($urandom_range(10, 15));
        else o = 4'($urandom_range(0, 9));
        if (minutes && $urandom_range(0, 2) != 0) o = 4'd0;
        return {t, o};
    endfunction

    // Scoreboard monitor: one expected snapshot per clock edge.
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            cycle_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("cycle %0d outputs", cycle_n), dut_vec, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("reset before any edge", dut_vec, 20'h00000);
        repeat (2) @(posedge clk);

        // 00:03 down to DONE, then alarm expires after AT ticks
        ld(8'h00, 8'h03);
        go();
        tick(); nop(); tick(); nop(); tick();
        nop(); nop();
        tick(); nop(); tick(); tick(); nop();

        // rejected preset, then start at 00:00 is ignored
        ld(8'h00, 8'h6A);
        nop();
        go(); nop();

        // borrow across minutes
        ld(8'h10, 8'h00); go(); tick(); nop();
        ld(8'h01, 8'h00); go(); tick(); nop();
        ld(8'h59, 8'h59); go(); tick(); nop(); cyc(0, 8'h00, 8'h00, 0, 0, 1, 0);

        // pause with coincident tick, ticks while paused, resume with tick
        ld(8'h00, 8'h05); go();
        cyc(0, 8'h00, 8'h00, 0, 1, 0, 1);
        tick(); tick();
        cyc(0, 8'h00, 8'h00, 1, 0, 0, 1);
        tick(); nop();

        // load during RUN forces IDLE without decrement
        cyc(1, 8'h00, 8'h02, 0, 0, 0, 1);
        go(); tick(); tick(); nop();
        tick();
        cyc(0, 8'h00, 8'h00, 1, 1, 0, 1);
        cyc(0, 8'h00, 8'h00, 0, 0, 1, 0);
        nop(); tick(); nop();

        // async reset in RUN at 12:34
        ld(8'h12, 8'h34); go(); tick(); nop();
        async_rst("async reset in RUN");
        nop(); tick(); nop();

        // async reset during DONE
        ld(8'h00, 8'h01); go(); tick(); nop();
        async_rst("async reset in DONE");
        nop(); nop();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_rst($sformatf("random async reset %0d", i));
            end else begin
                cyc($urandom_range(0, 19) == 0, rand_preset(1'b1), rand_preset(1'b0),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
            end
        end
        nop(); nop();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
